// File: rtl/fc_input_sequencer.sv
// Collects a stream of signed elements into an N_IN-wide vector, hands it to an FC layer,
// then waits for completion (or a timeout), captures the result and clears the layer.
module fc_input_sequencer #(
    parameter int N_IN    = 9,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic signed [DW-1:0]   in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [N_IN*DW-1:0]     fc_vec,
    output logic                   fc_enable,
    output logic                   fc_rst,
    input  logic                   fc_done,
    input  logic signed [DW-1:0]   fc_result,
    output logic                   res_valid,
    output logic [DW-1:0]          res_data,
    output logic                   err_timeout,
    output logic [1:0]             state_dbg
);

    // Handshake: an element transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state (and reset), never on in_valid.

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     wcnt;
    logic [DW-1:0]     slot [N_IN];
    logic              accept;
    logic              last_slot;
    logic              vec_end;
    logic              done_hit;
    logic              to_hit;

    assign accept    = in_valid && in_ready;
    assign last_slot = (idx == IW'(N_IN - 1));
    assign vec_end   = accept && (last_slot || in_last);
    assign done_hit  = (state == WAIT) && fc_done;
    assign to_hit    = (state == WAIT) && !fc_done && (wcnt == CW'(TIMEOUT - 1));

    // in_ready is also gated by reset so every output reads 0 while rst is low.
    assign in_ready  = (state == FILL) && rst;
    assign fc_enable = (state == ISSUE) || (state == WAIT);
    assign fc_rst    = (state == CLEAR);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (vec_end) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done_hit || to_hit) state_nxt = CLEAR;
            CLEAR:   state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx         <= '0;
            wcnt        <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            err_timeout <= 1'b0;
            for (int i = 0; i < N_IN; i++) slot[i] <= '0;
        end else begin
            res_valid <= done_hit;
            if (accept) begin
                idx <= vec_end ? '0 : idx + 1'b1;
            end
            // An early in_last zero-fills the untouched tail in the same edge.
            for (int i = 0; i < N_IN; i++) begin
                if (accept && (i == int'(idx))) begin
                    slot[i] <= in_data;
                end else if (vec_end && (i > int'(idx))) begin
                    slot[i] <= '0;
                end
            end
            if (state == ISSUE) begin
                wcnt <= '0;
            end else if (state == WAIT) begin
                wcnt <= wcnt + 1'b1;
            end
            if (done_hit) res_data <= fc_result;
            if (to_hit) err_timeout <= 1'b1;
        end
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_pack
        assign fc_vec[g*DW +: DW] = slot[g];
    end

endmodule

// File: tb/tb_fc_input_sequencer.sv
// Directed bench for fc_input_sequencer: full and short vectors, done, timeout,
// done-at-timeout, mid-transaction reset and a throttled-valid stream.
module tb_fc_input_sequencer;

    localparam int N_IN = 9;
    localparam int DW   = 32;
    localparam int VW   = N_IN * DW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_last;
    logic                 in_ready;
    logic [VW-1:0]        fc_vec;
    logic                 fc_enable;
    logic                 fc_rst;
    logic                 fc_done;
    logic signed [DW-1:0] fc_result;
    logic                 res_valid;
    logic [DW-1:0]        res_data;
    logic                 err_timeout;
    logic [1:0]           state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    logic [VW-1:0] exp_vec;
    int            cnt;
    int            sent;

    always #5 clk = ~clk;

    fc_input_sequencer #(.N_IN(N_IN), .DW(DW), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .fc_vec      (fc_vec),
        .fc_enable   (fc_enable),
        .fc_rst      (fc_rst),
        .fc_done     (fc_done),
        .fc_result   (fc_result),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .err_timeout (err_timeout),
        .state_dbg   (state_dbg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed_full(input int base);
        exp_vec = '0;
        for (int k = 0; k < N_IN; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(base + k);
            in_last  = 1'b0;
            exp_vec[k*DW +: DW] = DW'(base + k);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        fc_done = 1'b0; fc_result = '0;
        step(); step();
        check("rst_in_ready", in_ready, 0);
        check("rst_fc_vec", fc_vec, 0);
        check("rst_outs", {fc_enable, fc_rst, res_valid, err_timeout}, 0);
        check("rst_res_data", res_data, 0);
        rst = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_state", state_dbg, 0);

        // Full vector 1..9, completed with result 45.
        feed_full(1);
        check("full_vec", fc_vec, exp_vec);
        check("full_enable", fc_enable, 1);
        check("full_in_ready", in_ready, 0);
        step();
        check("wait_enable", fc_enable, 1);
        fc_done = 1'b1; fc_result = 45;
        step();
        fc_done = 1'b0;
        check("done_res_valid", res_valid, 1);
        check("done_res_data", res_data, 45);
        check("done_fc_rst", fc_rst, 1);
        check("done_enable", fc_enable, 0);
        check("done_vec_hold", fc_vec, exp_vec);
        step();
        check("post_res_valid", res_valid, 0);
        check("post_fc_rst", fc_rst, 0);
        check("post_in_ready", in_ready, 1);
        check("post_err", err_timeout, 0);

        // Short vector 7,-3,5 with in_last: tail of previous vector is zeroed.
        in_valid = 1'b1; in_last = 1'b0; in_data = 7;  step();
        in_data = -3; step();
        in_data = 5; in_last = 1'b1; step();
        in_valid = 1'b0; in_last = 1'b0;
        exp_vec = '0;
        exp_vec[0*DW +: DW] = 32'd7;
        exp_vec[1*DW +: DW] = 32'hFFFF_FFFD;
        exp_vec[2*DW +: DW] = 32'd5;
        check("short_vec", fc_vec, exp_vec);
        check("short_enable", fc_enable, 1);
        step();
        fc_done = 1'b1; fc_result = -9;
        step();
        fc_done = 1'b0;
        check("short_res_valid", res_valid, 1);
        check("short_res_data", res_data, 32'hFFFF_FFF7);
        step();

        // fc_done arrives on the last allowed WAIT cycle: done wins.
        feed_full(20);
        step();
        for (int c = 0; c < 63; c++) step();
        check("edge_still_wait", fc_enable, 1);
        fc_done = 1'b1; fc_result = 123;
        step();
        fc_done = 1'b0;
        check("edge_res_valid", res_valid, 1);
        check("edge_res_data", res_data, 123);
        check("edge_err", err_timeout, 0);
        step();

        // fc_done never arrives: timeout after 64 WAIT cycles.
        feed_full(40);
        step();
        for (int c = 0; c < 63; c++) step();
        check("to_pre_err", err_timeout, 0);
        check("to_pre_enable", fc_enable, 1);
        step();
        check("to_err", err_timeout, 1);
        check("to_res_valid", res_valid, 0);
        check("to_fc_rst", fc_rst, 1);
        check("to_res_data_kept", res_data, 123);
        step();
        check("to_back_fill", in_ready, 1);
        check("to_err_sticky", err_timeout, 1);
        check("to_fc_rst_off", fc_rst, 0);

        // Reset after four elements, then a clean full vector.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = DW'(60 + k); step();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_vec", fc_vec, 0);
        check("mid_rst_outs", {in_ready, fc_enable, fc_rst, res_valid, err_timeout}, 0);
        check("mid_rst_res_data", res_data, 0);
        step();
        check("mid_rst_no_pulse", {fc_rst, res_valid}, 0);
        rst = 1'b1;
        step();
        feed_full(11);
        check("rst_new_vec", fc_vec, exp_vec);
        step();
        fc_done = 1'b1; fc_result = 135;
        step();
        fc_done = 1'b0;
        check("rst_new_res", res_data, 135);
        step();

        // Throttled valid across FILL, ISSUE and WAIT: only FILL accepts.
        sent = 0;
        for (int v = 0; v < 2; v++) begin
            cnt = 0;
            exp_vec = '0;
            for (int guard = 0; guard < 200 && cnt < N_IN; guard++) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = DW'(100 + sent);
                if (in_valid) begin
                    exp_vec[cnt*DW +: DW] = DW'(100 + sent);
                    cnt++;
                    sent++;
                end
                step();
            end
            check("thr_count", cnt, N_IN);
            for (int c = 0; c < 4; c++) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 999;
                check("thr_in_ready", in_ready, 0);
                step();
                check("thr_vec", fc_vec, exp_vec);
            end
            in_valid = 1'b0;
            fc_done = 1'b1; fc_result = DW'(v);
            step();
            fc_done = 1'b0;
            check("thr_res", {res_valid, res_data}, {1'b1, DW'(v)});
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fc_input_sequencer.md
FC_INPUT_SEQUENCER -- requirements
Module: fc_input_sequencer

Interface
REQ-001 SHALL have parameter N_IN, default 9, the number of vector elements per FC transaction.
REQ-002 SHALL have parameter DW, default 32, the signed element width.
REQ-003 SHALL have parameter TIMEOUT, default 64, the maximum cycles to wait for fc_done before aborting.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (0 = reset).
REQ-006 SHALL have port in_valid, input, 1 bit: upstream element valid.
REQ-007 SHALL have port in_data, input, DW bits signed: upstream element.
REQ-008 SHALL have port in_last, input, 1 bit: element is last of its vector.
REQ-009 SHALL have port in_ready, output, 1 bit: sequencer accepts an element.
REQ-010 SHALL have port fc_vec, output, N_IN*DW bits: packed vector, element i at bits [i*DW +: DW].
REQ-011 SHALL have port fc_enable, output, 1 bit: request to FC layer.
REQ-012 SHALL have port fc_rst, output, 1 bit: active-high clear pulse to the FC layer.
REQ-013 SHALL have port fc_done, input, 1 bit: FC completion, sticky until fc_rst.
REQ-014 SHALL have port fc_result, input, DW bits signed: FC output.
REQ-015 SHALL have port res_valid, output, 1 bit: one-cycle result strobe.
REQ-016 SHALL have port res_data, output, DW bits: captured fc_result.
REQ-017 SHALL have port err_timeout, output, 1 bit: sticky timeout flag.

Function
REQ-018 SHALL implement states FILL, ISSUE, WAIT, CLEAR; FILL SHALL be the reset state.
REQ-019 SHALL assert in_ready only in FILL; an element is accepted when in_valid && in_ready.
REQ-020 SHALL write an accepted element to slot idx and increment idx (0..N_IN-1).
REQ-021 SHALL move FILL->ISSUE when the accepted element has idx==N_IN-1 or in_last=1.
REQ-022 SHALL zero-fill slots idx+1..N_IN-1 on an early in_last in the same cycle as the transition.
REQ-023 SHALL ignore in_last once idx==N_IN-1, completing the vector there; the next element SHALL start a new vector.
REQ-024 SHALL hold fc_vec stable from the ISSUE entry until the CLEAR exit.
REQ-025 SHALL hold fc_enable=1 in ISSUE and WAIT only; the final element accepted at edge N SHALL produce fc_enable=1 after edge N.
REQ-026 SHALL move ISSUE->WAIT unconditionally after one cycle.
REQ-027 SHALL clear the wait counter on WAIT entry and increment it each WAIT cycle.
REQ-028 SHALL, in WAIT with fc_done=1, capture fc_result into res_data, pulse res_valid for one cycle, and go to CLEAR.
REQ-029 SHALL, in WAIT when the counter reaches TIMEOUT-1 without fc_done, set err_timeout, skip the res_valid pulse, and go to CLEAR.
REQ-030 SHALL give fc_done priority over timeout when both occur in the same cycle.
REQ-031 SHALL ignore fc_done in FILL and CLEAR.
REQ-032 SHALL assert fc_rst=1 for exactly the one CLEAR cycle, then go to FILL with idx=0.
REQ-033 SHALL keep res_data until the next capture.
REQ-034 SHALL keep err_timeout set until rst.

Reset
REQ-035 SHALL asynchronously force, on rst=0: state FILL, idx 0, all fc_vec slots 0, fc_enable 0, fc_rst 0, res_valid 0, res_data 0, err_timeout 0, wait counter 0.
REQ-036 SHALL give in_ready=1 in the first cycle after rst is released.
REQ-037 SHALL, on rst asserted mid-transaction in any state, discard the partial vector with no res_valid and no fc_rst pulse.

Verification
REQ-038 SHALL be verified by: feed 1..9 on consecutive cycles -> fc_vec slots 1..9, fc_enable high the cycle after element 9, in_ready low; fc_done=1 with fc_result=45 -> res_data=45, res_valid one cycle, fc_rst one cycle, in_ready=1 next cycle.
REQ-039 SHALL be verified by: elements 7,-3,5 with in_last on 5 -> slots {7,-3,5,0,0,0,0,0,0}, fc_enable asserted.
REQ-040 SHALL be verified by: fc_done held 0 -> err_timeout=1 after 64 WAIT cycles, no res_valid, fc_rst pulse, return to FILL.
REQ-041 SHALL be verified by: fc_done and the timeout in the same cycle -> res_valid=1, err_timeout stays 0.
REQ-042 SHALL be verified by: rst low after element 4 -> all outputs 0; after release, a new full vector processes correctly from slot 0.
REQ-043 SHALL be verified by: in_valid toggled randomly during FILL, ISSUE and WAIT -> only elements accepted in FILL are stored, none lost or duplicated.
